// File: rtl/conv_output_collector.sv
// conv_output_collector
// Collects one set of pooled feature maps (one MapSize-word map per kernel)
// from the conv/pool stack, then drains the set kernel-major as a serial
// word stream toward the fully-connected stage.
//
// Output handshake: a word moves on every rising clk edge where
// out_valid && out_ready are both high. Once out_valid rises it stays high
// until the last word of the set has moved. While out_ready is low,
// out_data, out_kernel and out_last hold their values.
//
// busy mirrors the FSM state (1 = DRAIN, 0 = COLLECT). It serves as the
// state observation point.
module conv_output_collector #(
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int BitSize            = 32,
    parameter int MapWidth           = 2,
    localparam int KW                = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic                                         clk,
    input  logic                                         res_n,
    input  logic [NumberOfK-1:0]                         in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
    input  logic                                         in_set_done,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [BitSize-1:0]                           out_data,
    output logic [KW-1:0]                                out_kernel,
    output logic                                         out_last,
    output logic                                         busy,
    output logic                                         err_overflow
);

    localparam int MapSize = MapWidth * MapWidth;
    localparam int CW      = $clog2(MapSize + 1);
    localparam int IW      = (MapSize > 1) ? $clog2(MapSize) : 1;
    localparam logic [CW-1:0] FULL   = CW'(MapSize);
    localparam logic [IW-1:0] LAST_I = IW'(MapSize - 1);
    localparam logic [KW-1:0] LAST_K = KW'(NumberOfK - 1);

    typedef enum logic {S_COLLECT = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t               state_q;
    logic [BitSize-1:0]   mem_q  [NumberOfK][MapSize];
    logic [CW-1:0]        wcnt_q [NumberOfK];
    logic [CW-1:0]        wcnt_d [NumberOfK];
    logic [BitSize-1:0]   lane_data [NumberOfK];
    logic [NumberOfK-1:0] wr_en;
    logic [NumberOfK-1:0] drop;
    logic                 all_full_d;
    logic                 trigger;
    logic [BitSize-1:0]   first_word;
    logic [KW-1:0]        rd_k_q;
    logic [KW-1:0]        nxt_k;
    logic [IW-1:0]        rd_i_q;
    logic [IW-1:0]        nxt_i;

    // Kernel k is hard-wired to lane (k mod ProcessingElements).
    for (genvar g = 0; g < NumberOfK; g++) begin : g_lane
        assign lane_data[g] = in_data[g % ProcessingElements];
    end

    // Write enables, drops, next counts, drain trigger and next read index.
    always_comb begin
        wr_en      = '0;
        drop       = '0;
        all_full_d = 1'b1;
        for (int k = 0; k < NumberOfK; k++) begin
            wr_en[k]  = (state_q == S_COLLECT) && in_valid[k] && (wcnt_q[k] != FULL);
            drop[k]   = in_valid[k] && !wr_en[k];
            wcnt_d[k] = wr_en[k] ? wcnt_q[k] + 1'b1 : wcnt_q[k];
            if (wcnt_d[k] != FULL) begin
                all_full_d = 1'b0;
            end
        end
        trigger = (state_q == S_COLLECT) && (in_set_done || all_full_d);
        // The word for kernel 0 index 0 may be written on the trigger edge.
        // In that case it bypasses the storage so that the first word is correct.
        first_word = (wr_en[0] && (wcnt_q[0] == '0)) ? lane_data[0] : mem_q[0][0];
        if (rd_i_q == LAST_I) begin
            nxt_i = '0;
            nxt_k = rd_k_q + 1'b1;
        end else begin
            nxt_i = rd_i_q + 1'b1;
            nxt_k = rd_k_q;
        end
    end

    // Map storage: no reset. Entries not rewritten in a set keep their old data.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NumberOfK; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wcnt_q[k][IW-1:0]] <= lane_data[k];
            end
        end
    end

    // Collect/drain FSM with registered outputs and write counters.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= S_COLLECT;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_kernel   <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            rd_k_q       <= '0;
            rd_i_q       <= '0;
            for (int k = 0; k < NumberOfK; k++) begin
                wcnt_q[k] <= '0;
            end
        end else begin
            if (|drop) begin
                err_overflow <= 1'b1;
            end
            case (state_q)
                S_COLLECT: begin
                    for (int k = 0; k < NumberOfK; k++) begin
                        wcnt_q[k] <= wcnt_d[k];
                    end
                    if (trigger) begin
                        state_q    <= S_DRAIN;
                        busy       <= 1'b1;
                        out_valid  <= 1'b1;
                        out_data   <= first_word;
                        out_kernel <= '0;
                        out_last   <= (LAST_K == '0) && (LAST_I == '0);
                        rd_k_q     <= '0;
                        rd_i_q     <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state_q   <= S_COLLECT;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_k_q    <= '0;
                            rd_i_q    <= '0;
                            for (int k = 0; k < NumberOfK; k++) begin
                                wcnt_q[k] <= '0;
                            end
                        end else begin
                            rd_k_q     <= nxt_k;
                            rd_i_q     <= nxt_i;
                            out_data   <= mem_q[nxt_k][nxt_i];
                            out_kernel <= nxt_k;
                            out_last   <= (nxt_k == LAST_K) && (nxt_i == LAST_I);
                        end
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed bench for conv_output_collector (K=4, PE=2, 32-bit, 2x2 maps).
// Inputs change just after the falling edge. Outputs are sampled at the falling edge.
module tb_conv_output_collector;

    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic [3:0]       in_valid = '0;
    logic [1:0][31:0] in_data = '0;
    logic             in_set_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [1:0]       out_kernel;
    logic             out_last;
    logic             busy;
    logic             err_overflow;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl [4][4];
    logic [31:0] exp_q[$];

    conv_output_collector dut (
        .clk         (clk),
        .res_n       (res_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_set_done (in_set_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_kernel  (out_kernel),
        .out_last    (out_last),
        .busy        (busy),
        .err_overflow(err_overflow)
    );

    // clock
    always #5 clk = ~clk;

    // one input cycle, entered and left just after a falling edge
    task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic sd);
        in_valid    = v;
        in_data[0]  = d0;
        in_data[1]  = d1;
        in_set_done = sd;
        @(negedge clk);
        in_valid    = '0;
        in_set_done = 1'b0;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        out_ready = 1'b0;
        in_valid = '0;
        in_set_done = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
    endtask

    // full set with value base+16k+i. sd is applied with the last beat.
    task automatic fill_set(input logic [31:0] base, input logic sd);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0011, base + i, base + 16 + i, 1'b0);
            drive(4'b1100, base + 32 + i, base + 48 + i, (i == 3) ? sd : 1'b0);
            for (int k = 0; k < 4; k++) mdl[k][i] = base + 32'(16 * k) + i;
        end
    endtask

    // drain 16 words. mode 0: always ready. mode 1: ready 1,0,0,1,0,0...
    task automatic drain_check(input int mode, input string tag);
        int n, cyc;
        logic stalled, pl, rdy;
        logic [31:0] pd, w;
        logic [1:0] pk;
        n = 0; cyc = 0; stalled = 1'b0; pd = '0; pk = '0; pl = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) exp_q.push_back(mdl[k][i]);
        while (n < 16 && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_valid word=%0d: got valid=%b busy=%b want 1/1", tag, n, out_valid, busy);
            end
            if (stalled) begin
                total++;
                if (out_data !== pd || out_kernel !== pk || out_last !== pl) begin
                    bad++;
                    $display("FAIL %s_hold word=%0d: got %h/%0d/%b want %h/%0d/%b", tag, n,
                             out_data, out_kernel, out_last, pd, pk, pl);
                end
            end
            if (out_valid === 1'b1 && rdy) begin
                w = exp_q.pop_front();
                total++;
                if (out_data !== w || out_kernel !== 2'(n / 4) || out_last !== (n == 15)) begin
                    bad++;
                    $display("FAIL %s_word%0d: got data=%h k=%0d last=%b want data=%h k=%0d last=%b",
                             tag, n, out_data, out_kernel, out_last, w, n / 4, (n == 15));
                end
                n++;
            end
            stalled = (out_valid === 1'b1) && !rdy;
            pd = out_data; pk = out_kernel; pl = out_last;
            out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL %s_timeout: got %0d transfers want 16", tag, n);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: got valid=%b busy=%b last=%b want 0/0/0", tag, out_valid, busy, out_last);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || err_overflow !== 1'b0 ||
            out_data !== 32'h0 || out_kernel !== 2'd0) begin
            bad++;
            $display("FAIL reset: got v=%b l=%b b=%b e=%b d=%h k=%0d want all 0",
                     out_valid, out_last, busy, err_overflow, out_data, out_kernel);
        end
    endtask

    task automatic test_full_set();
        // no set_done: the all-full condition alone must start the drain
        fill_set(32'h0, 1'b0);
        drain_check(0, "full");
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_err: got %b want 0", err_overflow);
        end
    endtask

    task automatic test_backpressure();
        fill_set(32'h0, 1'b1);
        drain_check(1, "bp");
    endtask

    task automatic test_early_done();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0011, 32'h100 + i, 32'h200 + i, 1'b0);
            mdl[0][i] = 32'h100 + i;
            mdl[1][i] = 32'h200 + i;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL early_busy_pre: got %b want 0", busy);
        end
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drain_check(0, "early");
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL early_err: got %b want 0", err_overflow);
        end
    endtask

    task automatic test_simultaneous();
        // both kernels written on the same edge that samples set_done
        out_ready = 1'b0;
        drive(4'b0011, 32'hA, 32'hB, 1'b1);
        mdl[0][0] = 32'hA;
        mdl[1][0] = 32'hB;
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL simul_err_pre: got %b want 0", err_overflow);
        end
        // word arriving during drain: dropped and flagged
        drive(4'b0001, 32'hBEEF, 32'h0, 1'b0);
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL drain_drop_err: got %b want 1", err_overflow);
        end
        drain_check(0, "simul");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0011, 32'h1000 + i, 32'h1010 + i, 1'b0);
            mdl[0][i] = 32'h1000 + i;
            mdl[1][i] = 32'h1010 + i;
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b0100, 32'h1020 + i, 32'h0, 1'b0);
            mdl[2][i] = 32'h1020 + i;
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 32'h0, 32'h1030 + i, 1'b0);
            mdl[3][i] = 32'h1030 + i;
        end
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_err_pre: got %b want 0", err_overflow);
        end
        drive(4'b0100, 32'hDEAD, 32'h0, 1'b0);
        total++;
        if (err_overflow !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_collect: got err=%b busy=%b want 1/0", err_overflow, busy);
        end
        drive(4'b1000, 32'h0, 32'h1033, 1'b0);
        mdl[3][3] = 32'h1033;
        drain_check(0, "ovf");
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", err_overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_set(32'h2000, 1'b1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_data !== 32'h2011 || out_kernel !== 2'd1 || err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL mid_word5: got d=%h k=%0d err=%b want 2011/1/1", out_data, out_kernel, err_overflow);
        end
        res_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b b=%b l=%b e=%b want 0/0/0/0", out_valid, busy, out_last, err_overflow);
        end
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        fill_set(32'h3000, 1'b0);
        drain_check(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_set();
        test_backpressure();
        test_early_done();
        test_simultaneous();
        test_overflow();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
